// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memory geometry, port ids and read tag.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 64;
   localparam int DMEM_RD_LAT = 2;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_NIC = 1'b1;

   typedef struct packed {
      logic vld;
      logic port;
   } rd_tag_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// LAT-deep shift register of read tags matching the dmem read latency; clr_i empties it.
module dmem_rd_tag_pipe
   import dmem_pkg::*;
#(
   parameter int LAT = DMEM_RD_LAT
) (
   input  logic    clk,
   input  logic    clr_i,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t pipe_q [LAT];
   rd_tag_t pipe_d [LAT];

   always_comb begin
      pipe_d[0] = tag_i;
      for (int i = 1; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LAT; i++) begin
         if (clr_i) begin
            pipe_q[i] <= '0;
         end else begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign tag_o = pipe_q[LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for dmem with read-response routing.
// `define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int LAT    = DMEM_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_wr,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_wr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   rd_tag_t tag_in;
   rd_tag_t tag_out;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (!reset) begin
         p0_gnt = p0_req;
         p1_gnt = p1_req & ~p0_req;
      end
   end
`else
   logic last_gnt_q;
   logic last_gnt_d;

   // Under contention the port that did not win last time gets the slot.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (!reset) begin
         if (p0_req && p1_req) begin
            p0_gnt = (last_gnt_q == PORT_NIC);
            p1_gnt = (last_gnt_q == PORT_CPU);
         end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
         end
      end
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (p0_gnt || p1_gnt) begin
         last_gnt_d = p1_gnt ? PORT_NIC : PORT_CPU;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q <= PORT_NIC;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end
`endif

   assign mem_en    = p0_gnt | p1_gnt;
   assign mem_wr_en = p1_gnt ? p1_wr    : (p0_gnt ? p0_wr    : 1'b0);
   assign mem_addr  = p1_gnt ? p1_addr  : (p0_gnt ? p0_addr  : '0);
   assign mem_wdata = p1_gnt ? p1_wdata : (p0_gnt ? p0_wdata : '0);

   assign tag_in.vld  = mem_en & ~mem_wr_en;
   assign tag_in.port = p1_gnt ? PORT_NIC : PORT_CPU;

   dmem_rd_tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .clr_i (reset),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   assign p0_rvalid = ~reset & tag_out.vld & (tag_out.port == PORT_CPU);
   assign p1_rvalid = ~reset & tag_out.vld & (tag_out.port == PORT_NIC);
   assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
   assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 2-cycle dmem and a read scoreboard.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_wr, p1_req, p1_wr;
   logic [7:0]  p0_addr, p1_addr;
   logic [63:0] p0_wdata, p1_wdata;
   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [63:0] p0_rdata, p1_rdata;
   logic        mem_en, mem_wr_en;
   logic [7:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata_q = '0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_q)
   );

   // dmem: command captured at the grant edge, write lands / read data appears one edge later
   logic [63:0] dmem [256];
   logic        m_en1 = 1'b0, m_we1 = 1'b0;
   logic [7:0]  m_a1  = '0;
   logic [63:0] m_d1  = '0;

   always @(posedge clk) begin
      if (m_en1 && m_we1)  dmem[m_a1] <= m_d1;
      if (m_en1 && !m_we1) mem_rdata_q <= dmem[m_a1];
      m_en1 <= mem_en;
      m_we1 <= mem_wr_en;
      m_a1  <= mem_addr;
      m_d1  <= mem_wdata;
   end

   typedef struct {
      logic        port;
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] ref_mem [256];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [63:0] d0,
                        input logic r1, input logic w1, input logic [7:0] a1, input logic [63:0] d1);
      p0_req = r0; p0_wr = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_wr = w1; p1_addr = a1; p1_wdata = d1;
   endtask

   task automatic check_rd();
      logic        e0, e1;
      logic [63:0] d0, d1;
      exp_t        r;
      e0 = 1'b0; e1 = 1'b0; d0 = '0; d1 = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         if (r.port) begin e1 = 1'b1; d1 = r.data; end
         else        begin e0 = 1'b1; d0 = r.data; end
      end
      chk("p0_rvalid", {63'b0, p0_rvalid}, {63'b0, e0});
      chk("p1_rvalid", {63'b0, p1_rvalid}, {63'b0, e1});
      if (e0 || e1) begin
         chk("p0_rdata", p0_rdata, d0);
         chk("p1_rdata", p1_rdata, d1);
      end
   endtask

   // One clock cycle: check grants and memory drive mid-cycle, then advance.
   task automatic cycle(input logic eg0, input logic eg1);
      logic        wr;
      logic [7:0]  a;
      logic [63:0] d;
      @(negedge clk);
      chk("p0_gnt", {63'b0, p0_gnt}, {63'b0, eg0});
      chk("p1_gnt", {63'b0, p1_gnt}, {63'b0, eg1});
      chk("mem_en", {63'b0, mem_en}, {63'b0, eg0 | eg1});
      wr = eg1 ? p1_wr : (eg0 ? p0_wr : 1'b0);
      a  = eg1 ? p1_addr : (eg0 ? p0_addr : 8'h0);
      d  = eg1 ? p1_wdata : (eg0 ? p0_wdata : 64'h0);
      chk("mem_wr_en", {63'b0, mem_wr_en}, {63'b0, wr});
      chk("mem_addr", {56'b0, mem_addr}, {56'b0, a});
      if (wr || !(eg0 || eg1)) chk("mem_wdata", mem_wdata, d);
      if (eg0 || eg1) begin
         if (wr) ref_mem[a] = d;
         else    sb.push_back('{port: eg1, data: ref_mem[a], due: cyc + 2});
      end
      check_rd();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 8'h0, 64'h0, 0, 0, 8'h0, 64'h0);
      for (int i = 0; i < n; i++) cycle(0, 0);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 8'h0, 64'h0, 0, 0, 8'h0, 64'h0);
      sb.delete();
      for (int i = 0; i < 3; i++) cycle(0, 0);
      reset = 1'b0;
      idle(5);

      // single-port write then read-back
      drive(1, 1, 8'h10, 64'hDEAD_BEEF_0123_4567, 0, 0, 8'h0, 64'h0);
      cycle(1, 0);
      drive(1, 0, 8'h10, 64'h0, 0, 0, 8'h0, 64'h0);
      cycle(1, 0);
      idle(4);

      // preload through port 1 so port 0 owns the next contention
      drive(0, 0, 8'h0, 64'h0, 1, 1, 8'h01, 64'h1);
      cycle(0, 1);
      drive(0, 0, 8'h0, 64'h0, 1, 1, 8'h02, 64'h2);
      cycle(0, 1);

      drive(1, 0, 8'h01, 64'h0, 1, 0, 8'h02, 64'h0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) cycle(1, 0);
`else
      for (int i = 0; i < 2; i++) begin
         cycle(1, 0);
         cycle(0, 1);
      end
`endif
      idle(4);

      // cross-port coherence
      drive(0, 0, 8'h0, 64'h0, 1, 1, 8'hFF, 64'hA5A5);
      cycle(0, 1);
      drive(1, 0, 8'hFF, 64'h0, 0, 0, 8'h0, 64'h0);
      cycle(1, 0);
      idle(4);

      // lone requester streams back-to-back reads with an idle peer
      drive(0, 0, 8'h0, 64'h0, 1, 0, 8'h01, 64'h0);
      cycle(0, 1);
      p1_addr = 8'h02;
      cycle(0, 1);
      p1_addr = 8'hFF;
      cycle(0, 1);
      idle(4);

      // reset while a read is in flight
      drive(1, 0, 8'h10, 64'h0, 0, 0, 8'h0, 64'h0);
      cycle(1, 0);
      p0_req = 1'b0;
      reset  = 1'b1;
      sb.delete();
      cycle(0, 0);
      reset = 1'b0;
      idle(3);
      drive(1, 0, 8'h10, 64'h0, 0, 0, 8'h0, 64'h0);
      cycle(1, 0);
      idle(4);

      // requests held through reset arbitrate from the first cycle out of reset
      drive(1, 0, 8'h01, 64'h0, 1, 0, 8'h02, 64'h0);
      reset = 1'b1;
      sb.delete();
      cycle(0, 0);
      cycle(0, 0);
      reset = 1'b0;
      cycle(1, 0);
      p0_req = 1'b0;
      cycle(0, 1);
      idle(4);

      n_cmp++;
      assert (sb.size() == 0) else begin
         n_err++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
